// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master bus arbiter.
// State encoding, master index type and bus direction constants.
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef logic midx_t;

   localparam logic WR = 1'b1;
   localparam logic RD = 1'b0;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request side (two masters) and shared bus side of the arbiter.
// master: arbiter view; slave: requesters/target view.
interface bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req0;
   logic              wr_rd0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              ack0;
   logic              req1;
   logic              wr_rd1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              ack1;
   logic [DATA_W-1:0] rdata;
   logic              bus_cs;
   logic              bus_wr_rd;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ready;
   logic              err;

   modport master (
      input  req0, wr_rd0, addr0, wdata0,
      input  req1, wr_rd1, addr1, wdata1,
      input  bus_rdata, bus_ready,
      output ack0, ack1, rdata, err,
      output bus_cs, bus_wr_rd, bus_addr, bus_wdata
   );

   modport slave (
      output req0, wr_rd0, addr0, wdata0,
      output req1, wr_rd1, addr1, wdata1,
      output bus_rdata, bus_ready,
      input  ack0, ack1, rdata, err,
      input  bus_cs, bus_wr_rd, bus_addr, bus_wdata
   );

endinterface

// File: rtl/bus_wait_timer.sv
// Loadable down-counter that stops at zero; zero flag is combinational.
// Ports: clk, rst (async active-low), load/load_val, en, zero.
module bus_wait_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (en && !zero)
         count <= count - 1'b1;
   end

   assign zero = (count == '0);

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one external bus between two masters.
// Ports: clk, rst (async active-low), bus (bus_arbiter_if.master).
// Optional timeout abort enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int WAIT_CYCLES    = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic          clk,
   input  logic          rst,
   bus_arbiter_if.master bus
);

   state_e            state;
   midx_t             last_grant;
   midx_t             gnt;
   midx_t             pick;
   logic              grant_go;
   logic              done_ok;
   logic              to_hit;
   logic              wait_zero;
   logic              sel_wr_rd;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   always_comb begin
      pick = 1'b0;
      if (bus.req0 && bus.req1)
         pick = ~last_grant;
      else if (bus.req1)
         pick = 1'b1;
      sel_wr_rd = pick ? bus.wr_rd1 : bus.wr_rd0;
      sel_addr  = pick ? bus.addr1  : bus.addr0;
      sel_wdata = pick ? bus.wdata1 : bus.wdata0;
   end

   assign grant_go = (state == IDLE) && (bus.req0 || bus.req1);
   assign done_ok  = (state == ACCESS) && wait_zero && bus.bus_ready;

   bus_wait_timer #(.W(8)) u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (grant_go),
      .load_val (8'(WAIT_CYCLES)),
      .en       (state == ACCESS),
      .zero     (wait_zero)
   );

`ifdef BUS_TIMEOUT_EN
   localparam int TO_LD = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   logic to_zero;

   // Loaded one short: zero is then seen in the last allowed ACCESS
   // cycle, so the abort lands exactly TIMEOUT_CYCLES after entry.
   bus_wait_timer #(.W(16)) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .load     (grant_go),
      .load_val (16'(TO_LD)),
      .en       (state == ACCESS),
      .zero     (to_zero)
   );

   assign to_hit = (state == ACCESS) && to_zero && !done_ok;
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         gnt           <= 1'b0;
         bus.ack0      <= 1'b0;
         bus.ack1      <= 1'b0;
         bus.err       <= 1'b0;
         bus.rdata     <= '0;
         bus.bus_cs    <= 1'b0;
         bus.bus_wr_rd <= 1'b0;
         bus.bus_addr  <= '0;
         bus.bus_wdata <= '0;
      end else begin
         bus.ack0 <= 1'b0;
         bus.ack1 <= 1'b0;
         bus.err  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_go) begin
                  bus.bus_cs    <= 1'b1;
                  bus.bus_wr_rd <= sel_wr_rd;
                  bus.bus_addr  <= sel_addr;
                  bus.bus_wdata <= sel_wdata;
                  gnt           <= pick;
                  last_grant    <= pick;
                  state         <= ACCESS;
               end
            end
            ACCESS: begin
               if (done_ok || to_hit) begin
                  if (done_ok && bus.bus_wr_rd == RD)
                     bus.rdata <= bus.bus_rdata;
                  bus.bus_cs <= 1'b0;
                  bus.ack0   <= (gnt == 1'b0);
                  bus.ack1   <= (gnt == 1'b1);
                  bus.err    <= to_hit;
                  state      <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
